sprite_engine: RTL and testbench



---
 rtl/sprite_pkg.sv | 25 ++
 rtl/obj_motion.sv | 88 ++++++++
 rtl/sprite_engine.sv | 138 +++++++++++++
 tb/tb_sprite_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite renderer: coordinate width,
// the 2-bit-per-channel colour struct and the object palette.
package sprite_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } colour_t;

    localparam colour_t BLACK  = '{r: 2'b00, g: 2'b00, b: 2'b00};
    localparam colour_t WHITE  = '{r: 2'b11, g: 2'b11, b: 2'b11};
    localparam colour_t GREEN  = '{r: 2'b00, g: 2'b11, b: 2'b00};
    localparam colour_t RED    = '{r: 2'b11, g: 2'b00, b: 2'b00};
    localparam colour_t BLUE   = '{r: 2'b00, g: 2'b00, b: 2'b11};
    localparam colour_t YELLOW = '{r: 2'b11, g: 2'b11, b: 2'b00};

    // Object colour is PALETTE[index mod 4]; element 0 is the player's green.
    localparam colour_t [3:0] PALETTE = {YELLOW, BLUE, RED, GREEN};

endpackage

// File: rtl/obj_motion.sv
// Position and direction state for one square object. In PLAYER mode the
// buttons move it one pixel per step and the legal range acts as a clamp;
// otherwise it moves diagonally and reverses an axis instead of leaving
// the range (the position holds on the step that reverses).
module obj_motion
    import sprite_pkg::*;
#(
    parameter bit PLAYER      = 1'b0,
    parameter int INIT_X      = 40,
    parameter int INIT_Y      = 40,
    parameter bit INIT_DX_NEG = 1'b0,
    parameter int X_MIN       = 10,
    parameter int X_MAX       = 600,
    parameter int Y_MIN       = 10,
    parameter int Y_MAX       = 440
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [3:0] btn,     // {right, left, dn, up}
    output coord_t     ox,
    output coord_t     oy
);

    localparam logic [COORD_W:0] XMIN_W = (COORD_W+1)'(X_MIN);
    localparam logic [COORD_W:0] XMAX_W = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0] YMIN_W = (COORD_W+1)'(Y_MIN);
    localparam logic [COORD_W:0] YMAX_W = (COORD_W+1)'(Y_MAX);
    // Adding all-ones in COORD_W+1 bits is a decrement; an underflow lands
    // far above any legal maximum, so it fails the range test naturally.
    localparam logic [COORD_W:0] DEC_W  = '1;
    localparam logic [COORD_W:0] INC_W  = (COORD_W+1)'(1);

    logic                dx_neg, dy_neg;
    logic                dx_neg_n, dy_neg_n;
    coord_t              ox_n, oy_n;
    logic                x_move, y_move, x_dec, y_dec;
    logic                x_ok, y_ok;
    logic [COORD_W:0]    x_cand, y_cand;

    // Next position/direction for a motion step.
    always_comb begin
        ox_n     = ox;
        oy_n     = oy;
        dx_neg_n = dx_neg;
        dy_neg_n = dy_neg;
        if (PLAYER) begin
            // Opposing buttons cancel: move only when exactly one is held.
            x_move = btn[2] ^ btn[3];
            x_dec  = btn[2];
            y_move = btn[0] ^ btn[1];
            y_dec  = btn[0];
        end else begin
            x_move = 1'b1;
            x_dec  = dx_neg;
            y_move = 1'b1;
            y_dec  = dy_neg;
        end
        x_cand = {1'b0, ox} + (x_dec ? DEC_W : INC_W);
        y_cand = {1'b0, oy} + (y_dec ? DEC_W : INC_W);
        x_ok   = (x_cand >= XMIN_W) && (x_cand <= XMAX_W);
        y_ok   = (y_cand >= YMIN_W) && (y_cand <= YMAX_W);
        if (x_move) begin
            if (x_ok)         ox_n     = x_cand[COORD_W-1:0];
            else if (!PLAYER) dx_neg_n = ~dx_neg;
        end
        if (y_move) begin
            if (y_ok)         oy_n     = y_cand[COORD_W-1:0];
            else if (!PLAYER) dy_neg_n = ~dy_neg;
        end
    end

    // Object state register; only a motion step changes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ox     <= COORD_W'(INIT_X);
            oy     <= COORD_W'(INIT_Y);
            dx_neg <= INIT_DX_NEG;
            dy_neg <= 1'b0;
        end else if (step) begin
            ox     <= ox_n;
            oy     <= oy_n;
            dx_neg <= dx_neg_n;
            dy_neg <= dy_neg_n;
        end
    end

endmodule

// File: rtl/sprite_engine.sv
// Multi-object sprite renderer: composites border and NUM_OBJ squares into
// a registered 2-bit RGB pixel, steps object motion once every STEP_DIV
// frames, and reports which objects touched object 0 in the last frame.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int NUM_OBJ  = 4,
    parameter int OBJ_SIZE = 30,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BORDER   = 10,
    parameter int STEP_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  coord_t             x,
    input  coord_t             y,
    input  logic               blank,
    input  logic               frame_tick,
    input  logic [3:0]         btn,
    input  logic               pause,
    output logic [1:0]         r,
    output logic [1:0]         g,
    output logic [1:0]         b,
    output logic [NUM_OBJ-1:0] obj_hit
);

    localparam int X_MIN = BORDER;
    localparam int X_MAX = H_ACTIVE - BORDER - OBJ_SIZE;
    localparam int Y_MIN = BORDER;
    localparam int Y_MAX = V_ACTIVE - BORDER - OBJ_SIZE;

    localparam logic [COORD_W:0] SIZE_W  = (COORD_W+1)'(OBJ_SIZE);
    localparam logic [COORD_W:0] BL_W    = (COORD_W+1)'(BORDER);
    localparam logic [COORD_W:0] BR_W    = (COORD_W+1)'(H_ACTIVE - BORDER);
    localparam logic [COORD_W:0] BB_W    = (COORD_W+1)'(V_ACTIVE - BORDER);
    localparam logic [7:0]       DIV_LAST = 8'(STEP_DIV - 1);

    logic [COORD_W:0]   x_w, y_w;
    logic [7:0]         div_q;
    logic               step;
    coord_t             obj_x [NUM_OBJ];
    coord_t             obj_y [NUM_OBJ];
    logic [NUM_OBJ-1:0] obj_in;
    logic [NUM_OBJ-1:0] hit_now;
    logic [NUM_OBJ-1:0] hit_acc;
    logic               border;
    logic               found;
    colour_t            pix_d, pix_q;

    assign x_w  = {1'b0, x};
    assign y_w  = {1'b0, y};
    assign step = frame_tick && !pause && (div_q == DIV_LAST);

    // Frame divider: counts unpaused frame ticks, wraps on the step frame.
    always_ff @(posedge clk) begin
        if (!rst_n)
            div_q <= 8'd0;
        else if (frame_tick && !pause)
            div_q <= (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
    end

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        obj_motion #(
            .PLAYER      (i == 0),
            .INIT_X      (BORDER + 30 + 80 * i),
            .INIT_Y      (BORDER + 30 + 60 * i),
            .INIT_DX_NEG (i % 2 == 1),
            .X_MIN       (X_MIN),
            .X_MAX       (X_MAX),
            .Y_MIN       (Y_MIN),
            .Y_MAX       (Y_MAX)
        ) u_obj (
            .clk   (clk),
            .rst_n (rst_n),
            .step  (step),
            .btn   (btn),
            .ox    (obj_x[i]),
            .oy    (obj_y[i])
        );
    end

    // Shape tests for the current pixel against border and every object.
    always_comb begin
        obj_in = '0;
        border = (x_w < BL_W) || (x_w >= BR_W) || (y_w < BL_W) || (y_w >= BB_W);
        for (int i = 0; i < NUM_OBJ; i++) begin
            obj_in[i] = (x_w >= {1'b0, obj_x[i]}) && (x_w < {1'b0, obj_x[i]} + SIZE_W) &&
                        (y_w >= {1'b0, obj_y[i]}) && (y_w < {1'b0, obj_y[i]} + SIZE_W);
        end
    end

    // Colour priority: blank, then border, then the lowest-index object.
    always_comb begin
        pix_d = BLACK;
        found = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (!found && obj_in[i]) begin
                pix_d = PALETTE[2'(i)];
                found = 1'b1;
            end
        end
        if (border) pix_d = WHITE;
        if (blank)  pix_d = BLACK;
    end

    // Pixel output register (one cycle behind x/y/blank).
    always_ff @(posedge clk) begin
        if (!rst_n) pix_q <= BLACK;
        else        pix_q <= pix_d;
    end

    assign r = pix_q.r;
    assign g = pix_q.g;
    assign b = pix_q.b;

    // Visible pixels shared between object 0 and another object; bit 0 never sets.
    always_comb begin
        hit_now = '0;
        for (int i = 1; i < NUM_OBJ; i++)
            hit_now[i] = !blank && obj_in[i] && obj_in[0];
    end

    // Per-frame collision accumulation; a hit on the tick cycle belongs to
    // the frame that the tick starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_acc <= '0;
            obj_hit <= '0;
        end else if (frame_tick) begin
            obj_hit <= hit_acc;
            hit_acc <= hit_now;
        end else begin
            hit_acc <= hit_acc | hit_now;
        end
    end

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: a behavioural model of object
// motion, divider and collision feeds an expected-pixel queue.
module tb_sprite_engine;

    localparam int NUM_OBJ  = 4;
    localparam int OBJ_SIZE = 30;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int BORDER   = 10;
    localparam int STEP_DIV = 2;
    localparam int X_MIN    = BORDER;
    localparam int X_MAX    = H_ACTIVE - BORDER - OBJ_SIZE;
    localparam int Y_MIN    = BORDER;
    localparam int Y_MAX    = V_ACTIVE - BORDER - OBJ_SIZE;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [9:0]         x = '0;
    logic [9:0]         y = '0;
    logic               blank = 1'b1;
    logic               frame_tick = 1'b0;
    logic [3:0]         btn = '0;
    logic               pause = 1'b0;
    logic [1:0]         r, g, b;
    logic [NUM_OBJ-1:0] obj_hit;

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0] exp_q[$];

    // Reference model state
    int mox [NUM_OBJ];
    int moy [NUM_OBJ];
    int mdx [NUM_OBJ];
    int mdy [NUM_OBJ];
    int mdiv;
    logic [NUM_OBJ-1:0] m_acc, m_hit;

    sprite_engine #(
        .NUM_OBJ(NUM_OBJ), .OBJ_SIZE(OBJ_SIZE), .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE), .BORDER(BORDER), .STEP_DIV(STEP_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .blank(blank),
        .frame_tick(frame_tick), .btn(btn), .pause(pause),
        .r(r), .g(g), .b(b), .obj_hit(obj_hit)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic fail_bound(input string tag, input int waited);
        n_checks++;
        $display("FAIL %s: waited %0d ticks without reaching target state", tag, waited);
    endtask

    // ---------------- model ----------------
    function automatic bit in_obj(input int i, input int px, input int py);
        return px >= mox[i] && px < mox[i] + OBJ_SIZE && py >= moy[i] && py < moy[i] + OBJ_SIZE;
    endfunction

    function automatic logic [5:0] model_pix(input int px, input int py, input bit bl);
        logic [5:0] pal [4];
        pal[0] = 6'b001100; pal[1] = 6'b110000; pal[2] = 6'b000011; pal[3] = 6'b111100;
        if (bl) return 6'b000000;
        if (px < BORDER || px >= H_ACTIVE - BORDER || py < BORDER || py >= V_ACTIVE - BORDER)
            return 6'b111111;
        for (int i = 0; i < NUM_OBJ; i++)
            if (in_obj(i, px, py)) return pal[i % 4];
        return 6'b000000;
    endfunction

    function automatic void model_step(input logic [3:0] bt);
        int np;
        if (bt[0] && !bt[1] && moy[0] - 1 >= Y_MIN) moy[0] = moy[0] - 1;
        if (bt[1] && !bt[0] && moy[0] + 1 <= Y_MAX) moy[0] = moy[0] + 1;
        if (bt[2] && !bt[3] && mox[0] - 1 >= X_MIN) mox[0] = mox[0] - 1;
        if (bt[3] && !bt[2] && mox[0] + 1 <= X_MAX) mox[0] = mox[0] + 1;
        for (int i = 1; i < NUM_OBJ; i++) begin
            np = mox[i] + mdx[i];
            if (np >= X_MIN && np <= X_MAX) mox[i] = np; else mdx[i] = -mdx[i];
            np = moy[i] + mdy[i];
            if (np >= Y_MIN && np <= Y_MAX) moy[i] = np; else mdy[i] = -mdy[i];
        end
    endfunction

    function automatic bit overlap01();
        int ddx, ddy;
        ddx = mox[0] - mox[1];
        ddy = moy[0] - moy[1];
        return (ddx > -OBJ_SIZE) && (ddx < OBJ_SIZE) && (ddy > -OBJ_SIZE) && (ddy < OBJ_SIZE);
    endfunction

    // ---------------- reset ----------------
    task automatic apply_reset();
        rst_n = 1'b0; x = '0; y = '0; blank = 1'b0; frame_tick = 1'b0; btn = '0; pause = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_OBJ; i++) begin
            mox[i] = BORDER + 30 + 80 * i;
            moy[i] = BORDER + 30 + 60 * i;
            mdx[i] = (i % 2 == 1) ? -1 : 1;
            mdy[i] = 1;
        end
        mdiv = 0; m_acc = '0; m_hit = '0;
        check_eq("reset_rgb", {r, g, b}, 6'b000000);
        check_eq("reset_obj_hit", obj_hit, '0);
    endtask

    // ---------------- drivers ----------------
    // One clock: drive a pixel (and optionally a frame tick), predict,
    // then compare the registered pixel and, on ticks, the hit report.
    task automatic drive_cycle(input int px, input int py, input bit bl, input bit tk,
                               input logic [3:0] bt, input bit ps);
        logic [NUM_OBJ-1:0] hit_now;
        @(negedge clk);
        x = 10'(px); y = 10'(py); blank = bl; frame_tick = tk; btn = bt; pause = ps;
        exp_q.push_back(model_pix(px, py, bl));
        hit_now = '0;
        if (!bl)
            for (int i = 1; i < NUM_OBJ; i++)
                if (in_obj(i, px, py) && in_obj(0, px, py)) hit_now[i] = 1'b1;
        @(posedge clk);
        #1;
        if (tk) begin
            m_hit = m_acc;
            m_acc = hit_now;
            if (!ps) begin
                if (mdiv == STEP_DIV - 1) begin mdiv = 0; model_step(bt); end
                else mdiv = mdiv + 1;
            end
        end else begin
            m_acc = m_acc | hit_now;
        end
        check_eq("rgb", {r, g, b}, exp_q.pop_front());
        if (tk) check_eq("obj_hit", obj_hit, m_hit);
        frame_tick = 1'b0;
    endtask

    task automatic pix_rand();
        drive_cycle($urandom_range(H_ACTIVE - 1), $urandom_range(V_ACTIVE - 1),
                    $urandom_range(7) == 0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic tick_rand(input logic [3:0] bt, input bit ps);
        drive_cycle($urandom_range(H_ACTIVE - 1), $urandom_range(V_ACTIVE - 1),
                    $urandom_range(7) == 0, 1'b1, bt, ps);
    endtask

    // Pixels straddling each edge of object i.
    task automatic probe_obj(input int i);
        int px, py;
        px = mox[i]; py = moy[i];
        drive_cycle(px, py, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cycle(px - 1, py, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cycle(px, py - 1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cycle(px + OBJ_SIZE - 1, py + OBJ_SIZE - 1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cycle(px + OBJ_SIZE, py + OBJ_SIZE - 1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cycle(px + OBJ_SIZE - 1, py + OBJ_SIZE, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k, opx, opy;
        apply_reset();

        // Border, object 0 edge, blank.
        drive_cycle(0, 0, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cycle(40, 40, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cycle(39, 40, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cycle(40, 40, 1'b1, 1'b0, 4'b0000, 1'b0);
        drive_cycle(H_ACTIVE - BORDER, 200, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_cycle(300, V_ACTIVE - BORDER - 1, 1'b0, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < NUM_OBJ; i++) probe_obj(i);
        repeat (20) pix_rand();

        // Player up to the top edge, then hold up against the clamp.
        for (k = 0; k < 200 && moy[0] > Y_MIN; k++) tick_rand(4'b0001, 1'b0);
        if (moy[0] > Y_MIN) fail_bound("player_top", k);
        probe_obj(0);
        repeat (6) tick_rand(4'b0001, 1'b0);
        probe_obj(0);
        // Opposing buttons on both axes.
        repeat (4) tick_rand(4'b1100, 1'b0);
        repeat (4) tick_rand(4'b0011, 1'b0);
        probe_obj(0);

        // Object 1 reaches the right limit moving right, then bounces.
        for (k = 0; k < 6000 && !(mox[1] == X_MAX && mdx[1] == 1); k++) tick_rand(4'b0000, 1'b0);
        if (!(mox[1] == X_MAX && mdx[1] == 1)) fail_bound("obj1_reach_right", k);
        for (k = 0; k < 4 && mdx[1] != -1; k++) tick_rand(4'b0000, 1'b0);
        probe_obj(1);
        for (k = 0; k < 4 && mox[1] != X_MAX - 1; k++) tick_rand(4'b0000, 1'b0);
        probe_obj(1);

        // Pause freezes motion and divider; then resume tick by tick.
        repeat (3) begin
            tick_rand(4'b0000, 1'b1);
            probe_obj(1);
        end
        probe_obj(2);
        repeat (3) begin
            tick_rand(4'b0000, 1'b0);
            probe_obj(1);
        end

        // Steer the player onto object 1.
        for (k = 0; k < 20000 && !overlap01(); k++) begin
            logic [3:0] bt;
            bt = 4'b0000;
            if (moy[1] < moy[0]) bt[0] = 1'b1; else if (moy[1] > moy[0]) bt[1] = 1'b1;
            if (mox[1] < mox[0]) bt[2] = 1'b1; else if (mox[1] > mox[0]) bt[3] = 1'b1;
            tick_rand(bt, 1'b0);
        end
        if (!overlap01()) fail_bound("chase_overlap", k);

        // Collision reporting with motion frozen.
        opx = (mox[0] > mox[1]) ? mox[0] : mox[1];
        opy = (moy[0] > moy[1]) ? moy[0] : moy[1];
        drive_cycle(opx, opy, 1'b0, 1'b1, 4'b0000, 1'b1);  // hit on the tick cycle
        drive_cycle(opx, opy, 1'b0, 1'b0, 4'b0000, 1'b1);  // overlap pixel shows object 0
        drive_cycle(0, 0, 1'b1, 1'b1, 4'b0000, 1'b1);
        check_eq("obj_hit_bit1", obj_hit[1], 1'b1);
        check_eq("obj_hit_bit0", obj_hit[0], 1'b0);
        drive_cycle(opx, opy, 1'b1, 1'b0, 4'b0000, 1'b1);  // blank: no accumulation
        drive_cycle(0, 0, 1'b1, 1'b1, 4'b0000, 1'b1);
        check_eq("obj_hit_clear", obj_hit, '0);
        probe_obj(0);
        repeat (20) pix_rand();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
